// File: rtl/register_readout_pkg.sv
// Shared definitions for the register readout path: FSM encoding and the
// nibble width common to the register write side.
package register_readout_pkg;

    localparam int DATA_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/register_snapshot.sv
// Captures the whole register bank on a load strobe and serves a registered
// read of one nibble, selected by the index the top will hold next cycle.
module register_snapshot
    import register_readout_pkg::*;
#(
    parameter int NUM_REGS  = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic                           clk,
    input  logic                           srst,
    input  logic                           load,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_data,
    input  logic [IDX_WIDTH-1:0]           rd_idx,
    output logic [DATA_WIDTH-1:0]          rd_data
);

    logic [DATA_WIDTH-1:0] snap_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] snap_d [NUM_REGS];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_slot
            always_comb begin
                snap_d[gi] = snap_q[gi];
                if (load) begin
                    snap_d[gi] = reg_data[gi*DATA_WIDTH +: DATA_WIDTH];
                end
            end

            always_ff @(posedge clk) begin
                if (srst) begin
                    snap_q[gi] <= '0;
                end else begin
                    snap_q[gi] <= snap_d[gi];
                end
            end
        end
    endgenerate

    // Reading from the next-state array lets the first beat appear the cycle
    // right after the load, without a bypass path in the top.
    always_comb begin
        rd_data_d = snap_d[rd_idx];
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/register_readout.sv
// Snapshots the register bank on START and streams a wrap-around window of it
// one nibble per valid/ready beat, followed by a single-cycle DONE.
module register_readout
    import register_readout_pkg::*;
#(
    parameter int NUM_REGS  = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic                           CLOCK,
    input  logic                           RESET,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] REG_DATA,
    input  logic                           START,
    input  logic [IDX_WIDTH-1:0]           FIRST_INDEX,
    input  logic [IDX_WIDTH:0]             COUNT,
    output logic                           BUSY,
    output logic [DATA_WIDTH-1:0]          OUT_DATA,
    output logic [IDX_WIDTH-1:0]           OUT_INDEX,
    output logic                           OUT_VALID,
    input  logic                           OUT_READY,
    output logic                           OUT_LAST,
    output logic                           DONE
);

    localparam logic [IDX_WIDTH:0] MAX_COUNT = (IDX_WIDTH+1)'(NUM_REGS);

    state_e                state_q, state_d;
    logic [IDX_WIDTH-1:0]  index_q, index_d;
    logic [IDX_WIDTH:0]    remaining_q, remaining_d;
    logic [IDX_WIDTH:0]    eff_count;
    logic                  load;
    logic [DATA_WIDTH-1:0] snap_data;
    logic                  sending;

    register_snapshot #(
        .NUM_REGS  (NUM_REGS),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_snapshot (
        .clk      (CLOCK),
        .srst     (RESET),
        .load     (load),
        .reg_data (REG_DATA),
        .rd_idx   (index_d),
        .rd_data  (snap_data)
    );

    // Clamping to the bank size guarantees no register repeats within one transfer.
    assign eff_count = (COUNT > MAX_COUNT) ? MAX_COUNT : COUNT;

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        remaining_d = remaining_q;
        load        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    load        = 1'b1;
                    index_d     = FIRST_INDEX;
                    remaining_d = eff_count;
                    state_d     = (eff_count == '0) ? ST_DONE : ST_SEND;
                end
            end
            ST_SEND: begin
                if (OUT_READY) begin
                    index_d     = index_q + IDX_WIDTH'(1);
                    remaining_d = remaining_q - (IDX_WIDTH+1)'(1);
                    if (remaining_q == (IDX_WIDTH+1)'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            index_q     <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            remaining_q <= remaining_d;
        end
    end

    assign sending   = (state_q == ST_SEND);
    assign OUT_VALID = sending;
    assign OUT_DATA  = sending ? snap_data : '0;
    assign OUT_INDEX = sending ? index_q : '0;
    assign OUT_LAST  = sending && (remaining_q == (IDX_WIDTH+1)'(1));
    assign DONE      = (state_q == ST_DONE);
    assign BUSY      = sending || (state_q == ST_DONE);

endmodule

// File: tb/tb_register_readout.sv
// Directed-vector bench for register_readout: reset, streaming, wrap,
// backpressure, snapshot isolation, COUNT edge cases and mid-transfer reset.
module tb_register_readout;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] reg_data;
    logic        start;
    logic [1:0]  first_index;
    logic [2:0]  count;
    logic        busy;
    logic [3:0]  out_data;
    logic [1:0]  out_index;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        done;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    register_readout #(
        .NUM_REGS  (4),
        .IDX_WIDTH (2)
    ) dut (
        .CLOCK       (clk),
        .RESET       (rst),
        .REG_DATA    (reg_data),
        .START       (start),
        .FIRST_INDEX (first_index),
        .COUNT       (count),
        .BUSY        (busy),
        .OUT_DATA    (out_data),
        .OUT_INDEX   (out_index),
        .OUT_VALID   (out_valid),
        .OUT_READY   (out_ready),
        .OUT_LAST    (out_last),
        .DONE        (done)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_beat(input string tag, input logic [3:0] d, input logic [1:0] idx,
                               input logic last);
        check({tag, ".valid"}, {7'd0, out_valid}, 8'd1);
        check({tag, ".data"},  {4'd0, out_data},  {4'd0, d});
        check({tag, ".index"}, {6'd0, out_index}, {6'd0, idx});
        check({tag, ".last"},  {7'd0, out_last},  {7'd0, last});
        check({tag, ".done"},  {7'd0, done},      8'd0);
        check({tag, ".busy"},  {7'd0, busy},      8'd1);
    endtask

    task automatic expect_done(input string tag);
        check({tag, ".done"},  {7'd0, done},      8'd1);
        check({tag, ".valid"}, {7'd0, out_valid}, 8'd0);
        check({tag, ".busy"},  {7'd0, busy},      8'd1);
        check({tag, ".data"},  {4'd0, out_data},  8'd0);
        check({tag, ".last"},  {7'd0, out_last},  8'd0);
    endtask

    task automatic expect_idle(input string tag);
        check({tag, ".busy"},  {7'd0, busy},      8'd0);
        check({tag, ".valid"}, {7'd0, out_valid}, 8'd0);
        check({tag, ".done"},  {7'd0, done},      8'd0);
        check({tag, ".data"},  {4'd0, out_data},  8'd0);
        check({tag, ".index"}, {6'd0, out_index}, 8'd0);
        check({tag, ".last"},  {7'd0, out_last},  8'd0);
    endtask

    task automatic do_start(input logic [1:0] fi, input logic [2:0] cnt);
        first_index = fi;
        count       = cnt;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        reg_data    = 16'hD7A3;
        start       = 1'b1;
        first_index = 2'd0;
        count       = 3'd4;
        out_ready   = 1'b1;

        // Reset held with START asserted
        tick();
        expect_idle("rst0");
        tick();
        expect_idle("rst1");
        rst   = 1'b0;
        start = 1'b0;
        tick();
        expect_idle("post_rst");

        // Basic read of all four registers
        do_start(2'd0, 3'd4);
        expect_beat("basic0", 4'h3, 2'd0, 1'b0);
        tick();
        expect_beat("basic1", 4'hA, 2'd1, 1'b0);
        tick();
        expect_beat("basic2", 4'h7, 2'd2, 1'b0);
        tick();
        expect_beat("basic3", 4'hD, 2'd3, 1'b1);
        tick();
        expect_done("basic_done");
        tick();
        expect_idle("basic_idle");

        // Wrap-around with backpressure
        out_ready = 1'b0;
        do_start(2'd3, 3'd2);
        expect_beat("bp_hold0", 4'hD, 2'd3, 1'b0);
        tick();
        expect_beat("bp_hold1", 4'hD, 2'd3, 1'b0);
        tick();
        expect_beat("bp_hold2", 4'hD, 2'd3, 1'b0);
        out_ready = 1'b1;
        tick();
        expect_beat("wrap1", 4'h3, 2'd0, 1'b1);
        tick();
        expect_done("wrap_done");
        tick();
        expect_idle("wrap_idle");

        // Snapshot isolation and START ignored mid-transfer
        do_start(2'd0, 3'd4);
        reg_data = 16'h0000;
        expect_beat("iso0", 4'h3, 2'd0, 1'b0);
        tick();
        expect_beat("iso1", 4'hA, 2'd1, 1'b0);
        start       = 1'b1;
        first_index = 2'd2;
        count       = 3'd1;
        tick();
        start = 1'b0;
        expect_beat("iso2", 4'h7, 2'd2, 1'b0);
        tick();
        expect_beat("iso3", 4'hD, 2'd3, 1'b1);
        tick();
        expect_done("iso_done");
        tick();
        expect_idle("iso_idle0");
        tick();
        expect_idle("iso_idle1");
        reg_data = 16'hD7A3;

        // COUNT = 0 goes straight to DONE
        do_start(2'd1, 3'd0);
        expect_done("cnt0_done");
        tick();
        expect_idle("cnt0_idle");

        // COUNT = 7 clamps to four beats
        do_start(2'd0, 3'd7);
        expect_beat("cnt7_0", 4'h3, 2'd0, 1'b0);
        tick();
        expect_beat("cnt7_1", 4'hA, 2'd1, 1'b0);
        tick();
        expect_beat("cnt7_2", 4'h7, 2'd2, 1'b0);
        tick();
        expect_beat("cnt7_3", 4'hD, 2'd3, 1'b1);
        tick();
        expect_done("cnt7_done");
        tick();
        expect_idle("cnt7_idle");

        // Reset during the second beat drops the transfer without DONE
        do_start(2'd0, 3'd4);
        expect_beat("mid0", 4'h3, 2'd0, 1'b0);
        tick();
        expect_beat("mid1", 4'hA, 2'd1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_idle("mid_rst");
        tick();
        expect_idle("mid_rst_after");

        // Fresh transfer after the aborted one
        do_start(2'd2, 3'd1);
        expect_beat("restart0", 4'h7, 2'd2, 1'b1);
        tick();
        expect_done("restart_done");
        tick();
        expect_idle("restart_idle");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
